// File: rtl/rom_stream_pkg.sv
// rom_stream_pkg: shared types and sizing constants for the ROM burst reader.
`timescale 1ns/1ps

package rom_stream_pkg;

    localparam int ROM_DEPTH  = 8;
    localparam int ROM_ADDR_W = 3;
    localparam int CNT_W      = 4;
    localparam int FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/rom_stream_fifo2.sv
// rom_stream_fifo2: two-entry FIFO whose head always sits in slot 0, so the
// head word comes straight from a register and stays put while not popped.
`timescale 1ns/1ps

module rom_stream_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] slot1;
    logic         do_pop;

    assign do_pop = pop && (count != 2'd0);

    // Shift-style storage: pops move slot 1 forward, pushes fill the first free slot.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            head  <= '0;
            slot1 <= '0;
            count <= 2'd0;
        end else begin
            unique case ({push, do_pop})
                2'b10: begin
                    if (count == 2'd0) head <= push_data;
                    else               slot1 <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= push_data;
                    end else begin
                        head  <= slot1;
                        slot1 <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/rom_stream_reader.sv
// rom_stream_reader: walks a wrap-around ROM address window on start, absorbs
// the ROM's one-cycle read latency with a 2-entry FIFO and streams the words
// out over valid/ready. Optional burst sum is enabled with ROM_STREAM_SUM_EN.
`timescale 1ns/1ps

module rom_stream_reader
    import rom_stream_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  start,
    input  logic [ROM_ADDR_W-1:0] base,
    input  logic [CNT_W-1:0]      count,
    output logic                  busy,
    output logic [ROM_ADDR_W-1:0] rom_add,
    input  logic [N-1:0]          rom_q,
    output logic [N-1:0]          out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  done
`ifdef ROM_STREAM_SUM_EN
    ,
    output logic [N+2:0]          sum
`endif
);

    state_t                state;
    logic [ROM_ADDR_W-1:0] base_r;
    logic [CNT_W-1:0]      len;
    logic [CNT_W-1:0]      issued;
    logic [CNT_W-1:0]      next_off;
    logic [CNT_W-1:0]      sat_count;
    logic                  inflight;
    logic                  inflight_last;
    logic                  accept;
    logic                  last_issue;
    logic                  issue_ok;
    logic [2:0]            credit;
    logic                  pop;
    logic [N:0]            head;
    logic [1:0]            fifo_count;

    assign sat_count  = (count > CNT_W'(ROM_DEPTH)) ? CNT_W'(ROM_DEPTH) : count;
    assign accept     = (state == ST_IDLE) && start && (count != '0);
    assign next_off   = issued + CNT_W'(1);
    assign last_issue = (issued == len - CNT_W'(1));

    // Words already buffered plus the one in flight, minus the one leaving now,
    // must leave room for the word this issue will produce two edges later.
    assign pop      = out_valid && out_ready;
    assign credit   = 3'(fifo_count) + 3'(inflight) - 3'(pop);
    assign issue_ok = (state == ST_ISSUE) && (credit < 3'(FIFO_DEPTH));

    assign out_valid = (fifo_count != 2'd0);
    assign out_data  = head[N-1:0];
    assign out_last  = out_valid && head[N];

    rom_stream_fifo2 #(
        .W(N + 1)
    ) u_fifo (
        .clk       (clk),
        .clr       (clr),
        .push      (inflight),
        .push_data ({inflight_last, rom_q}),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    // Burst sequencer: latch the request, issue addresses under credit, then wait for the last handshake.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state         <= ST_IDLE;
            base_r        <= '0;
            len           <= '0;
            issued        <= '0;
            rom_add       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            done          <= 1'b0;
            inflight      <= issue_ok;
            inflight_last <= issue_ok && last_issue;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        base_r  <= base;
                        len     <= sat_count;
                        issued  <= '0;
                        rom_add <= base;
                        busy    <= 1'b1;
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (issue_ok) begin
                        issued <= next_off;
                        if (last_issue) state   <= ST_DRAIN;
                        else            rom_add <= base_r + next_off[ROM_ADDR_W-1:0];
                    end
                end
                ST_DRAIN: begin
                    if (pop && out_last) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef ROM_STREAM_SUM_EN
    // Running burst total: cleared on an accepted start, accumulates each word entering the FIFO.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sum <= '0;
        end else if (accept) begin
            sum <= '0;
        end else if (inflight) begin
            sum <= sum + {3'b000, rom_q};
        end
    end
`endif

endmodule

// File: tb/tb_rom_stream_reader.sv
// tb_rom_stream_reader: table-driven bursts against a registered 8-word ROM
// model (word[i] = 8 - i), plus hand-written reset-mid-burst sequence.
`timescale 1ns/1ps

module tb_rom_stream_reader;

    logic        clk;
    logic        clr;
    logic        start;
    logic [2:0]  base;
    logic [3:0]  count;
    logic        busy;
    logic [2:0]  rom_add;
    logic [7:0]  rom_q;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        done;
`ifdef ROM_STREAM_SUM_EN
    logic [10:0] sum;
`endif

    int tests;
    int failures;

    // mode 0: ready held 1; mode 1: toggle then stall 5 cycles; mode 2: ready 1 plus a start pulse while busy
    typedef struct {
        logic [2:0]      base;
        logic [3:0]      count;
        int              mode;
        int              n;
        logic [0:7][7:0] words;
        int              sum;
    } vec_t;

    vec_t vecs[6];

    rom_stream_reader #(.N(8)) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .base      (base),
        .count     (count),
        .busy      (busy),
        .rom_add   (rom_add),
        .rom_q     (rom_q),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .done      (done)
`ifdef ROM_STREAM_SUM_EN
        ,
        .sum       (sum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: registered one-cycle read, word[i] = 8 - i
    always @(posedge clk) rom_q <= 8'(8 - int'(rom_add));

    task automatic check_output(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_sum(input int expected);
`ifdef ROM_STREAM_SUM_EN
        check_output("sum", int'(sum), expected);
`endif
    endtask

    task automatic run_burst(input vec_t v);
        int   got;
        int   first_k;
        int   last_k;
        int   done_k;
        logic pv;
        logic pr;
        logic [7:0] pd;
        @(negedge clk);
        start     = 1'b1;
        base      = v.base;
        count     = v.count;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_output("busy_after_start", int'(busy), (v.n > 0) ? 1 : 0);
        if (v.n > 0) check_output("first_rom_add", int'(rom_add), int'(v.base));
        got = 0; first_k = -1; last_k = -1; done_k = -1; pv = 1'b0; pr = 1'b1; pd = '0;
        for (int k = 0; k < 60; k++) begin
            if (k > 0) @(negedge clk);
            if (v.mode == 2 && k == 1) begin
                start = 1'b1; base = 3'd4; count = 4'd2;
            end else begin
                start = 1'b0;
            end
            if (v.mode == 1) out_ready = (k < 10) ? (k % 2 == 0) : (k >= 15);
            else             out_ready = 1'b1;
            if (pv && !pr) begin
                check_output("stall_valid_held", int'(out_valid), 1);
                check_output("stall_data_held", int'(out_data), int'(pd));
            end
            if (out_valid && out_ready) begin
                if (got < v.n) begin
                    check_output("word_data", int'(out_data), int'(v.words[got]));
                    check_output("word_last", int'(out_last), (got == v.n - 1) ? 1 : 0);
                end else begin
                    check_output("extra_word", got, v.n - 1);
                end
                if (got == 0) first_k = k;
                last_k = k;
                got++;
            end
            if (done) begin
                done_k = k;
                check_output("busy_in_done_cycle", int'(busy), 0);
                break;
            end
            pv = out_valid; pr = out_ready; pd = out_data;
            if (v.n == 0 && k == 9) break;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        check_output("word_count", got, v.n);
        if (v.n > 0) begin
            check_output("done_after_last", done_k, last_k + 1);
            if (v.mode == 0) begin
                check_output("first_word_latency", first_k, 2);
                check_output("last_word_cycle", last_k, v.n + 1);
            end
        end else begin
            check_output("noop_done", done_k, -1);
            check_output("noop_busy", int'(busy), 0);
        end
        check_sum(v.sum);
    endtask

    task automatic apply_stimulus();
        vec_t one;
        int   stray;
        for (int i = 0; i < 6; i++) run_burst(vecs[i]);

        // reset two cycles into a burst, then a single-word burst
        @(negedge clk);
        start = 1'b1; base = 3'd0; count = 4'd8;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        #1;
        check_output("clr_busy", int'(busy), 0);
        check_output("clr_rom_add", int'(rom_add), 0);
        check_output("clr_out_valid", int'(out_valid), 0);
        check_output("clr_out_data", int'(out_data), 0);
        check_output("clr_out_last", int'(out_last), 0);
        check_output("clr_done", int'(done), 0);
        check_sum(0);
        @(negedge clk);
        clr = 1'b0;
        stray = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid || busy || done) stray++;
        end
        check_output("clr_no_stray", stray, 0);
        one = '{base: 3'd0, count: 4'd1, mode: 0, n: 1,
                words: {8'd8, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, sum: 8};
        run_burst(one);
    endtask

    initial begin
        tests = 0; failures = 0;
        clr = 1'b1; start = 1'b0; base = '0; count = '0; out_ready = 1'b1;

        vecs[0] = '{base: 3'd0, count: 4'd8, mode: 0, n: 8,
                    words: {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, sum: 36};
        vecs[1] = '{base: 3'd6, count: 4'd4, mode: 0, n: 4,
                    words: {8'd2, 8'd1, 8'd8, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0}, sum: 18};
        vecs[2] = '{base: 3'd3, count: 4'd0, mode: 0, n: 0,
                    words: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, sum: 18};
        vecs[3] = '{base: 3'd5, count: 4'd12, mode: 0, n: 8,
                    words: {8'd3, 8'd2, 8'd1, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4}, sum: 36};
        vecs[4] = '{base: 3'd2, count: 4'd5, mode: 1, n: 5,
                    words: {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd0, 8'd0, 8'd0}, sum: 20};
        vecs[5] = '{base: 3'd0, count: 4'd3, mode: 2, n: 3,
                    words: {8'd8, 8'd7, 8'd6, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, sum: 21};

        repeat (3) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        check_output("reset_busy", int'(busy), 0);
        check_output("reset_rom_add", int'(rom_add), 0);
        check_output("reset_out_valid", int'(out_valid), 0);
        check_output("reset_out_data", int'(out_data), 0);
        check_output("reset_out_last", int'(out_last), 0);
        check_output("reset_done", int'(done), 0);
        check_sum(0);

        apply_stimulus();

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
